// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte FIFO in front of the UART transmitter.
// Producers push bytes with WrEn/WrData; bytes are handed one at a time to the
// transmitter over the TxData/TxEn/TxDone level handshake.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          WrEn,
    input  logic [7:0]    WrData,
    output logic          Full,
    output logic          Empty,
    output logic [AW:0]   Count,
    output logic          Overflow,
    output logic [7:0]    TxData,
    output logic          TxEn,
    input  logic          TxDone,
    output logic          Busy
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } stateT;

    stateT         state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          overflow;
    logic          txEn;
    logic [7:0]    txData;
    logic          wrAccept;
    logic          pop;

    // Flags decode the registered count, so a write in the cycle Full is high is
    // dropped even if a pop frees a slot on the same edge.
    assign Full     = (count == FullCount);
    assign Empty    = (count == '0);
    assign Count    = count;
    assign Overflow = overflow;
    assign TxData   = txData;
    assign TxEn     = txEn;
    assign Busy     = (state != StIdle);

    // Reset (active high despite the name) blocks both transfers outright.
    assign wrAccept = WrEn && !Full && !Rst_n;
    assign pop      = (state == StIdle) && !Empty && !Rst_n;

    // Storage array; contents are not cleared by reset and only read behind rdPtr.
    always_ff @(posedge Clk) begin
        if (wrAccept) begin
            mem[wrPtr] <= WrData;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (WrEn && Full) begin
                overflow <= 1'b1;
            end
            if (wrAccept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wrAccept) begin
                count <= count - 1'b1;
            end
        end
    end

    // Transmit handshake FSM with registered TxEn/TxData; GAP waits for TxDone to
    // drop so one long TxDone level cannot complete two bytes.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            state  <= StIdle;
            txEn   <= 1'b0;
            txData <= 8'h00;
        end else begin
            case (state)
                StIdle: begin
                    if (pop) begin
                        txData <= mem[rdPtr];
                        txEn   <= 1'b1;
                        state  <= StSend;
                    end
                end
                StSend: begin
                    if (TxDone) begin
                        txEn  <= 1'b0;
                        state <= StGap;
                    end
                end
                StGap: begin
                    if (!TxDone) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    txEn  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer sitting directly upstream of the UART transmitter in the router top level. It accepts bytes from any producer through a simple write strobe, stores up to DEPTH bytes, and feeds them one at a time into the transmitter's TxData/TxEn/TxDone interface. This decouples producers from the serial bit rate. The previously undriven TxData net of the top level is now driven by this block.

## Interface

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, minimum 2.
- AW, 4, address width; must equal log2(DEPTH).

Ports:
- Clk  in  1  system clock. The block uses one clock: this one.
- Rst_n  in  1  reset. Synchronous and active-high despite the name: 1 = reset, sampled on the Clk rising edge.
- WrEn  in  1  write strobe; one byte is written per cycle in which WrEn is high.
- WrData  in  8  byte to enqueue; sampled when WrEn = 1.
- Full  out  1  FIFO holds DEPTH bytes.
- Empty  out  1  FIFO holds 0 bytes.
- Count  out  AW+1  number of bytes stored, 0..DEPTH.
- Overflow  out  1  sticky flag, set by a write attempted while Full; cleared only by reset.
- TxData  out  8  byte presented to the transmitter.
- TxEn  out  1  transmit request to the transmitter; held high for the whole byte.
- TxDone  in  1  transmitter completion, sampled as a level.
- Busy  out  1  high when the state is not IDLE.

## Operation

Storage:
- Circular buffer of DEPTH x 8 bits, with AW-bit write and read pointers.
- Both pointers wrap naturally from DEPTH-1 to 0.
- Count is an AW+1-bit register. Full = (Count == DEPTH) and Empty = (Count == 0); both are decoded from registered Count.

Write and pop rules:
- A write is accepted when WrEn = 1 and Full = 0. It stores WrData at the write pointer and advances the write pointer.
- A write while Full = 1 is dropped. Memory and pointers are unchanged, and Overflow is set to 1.
- A pop happens only in IDLE when Empty = 0. It loads mem[rd_ptr] into the TxData register and advances the read pointer.
- Accepted write and pop in the same cycle: Count unchanged, both pointers advance.
- Write and pop in the same cycle while Full: the write is still dropped, because Full is registered. Overflow is set and Count decrements.

State machine (IDLE, SEND, GAP):
- IDLE: TxEn = 0. If Empty = 0, pop, set TxEn = 1 and go to SEND.
- SEND: TxEn = 1 and TxData held stable. On the first cycle with TxDone = 1, set TxEn = 0 and go to GAP.
- GAP: TxEn = 0. Stay until TxDone = 0, then go to IDLE. This prevents one long TxDone level from being counted twice.

Reset, any time including mid-byte:
- Pointers = 0, Count = 0, state = IDLE.
- TxEn = 0, TxData = 8'h00, Overflow = 0.
- The stored byte contents are don't-care and are not cleared.

## Timing

Reset values:
- Full = 0, Empty = 1, Count = 0, Overflow = 0.
- TxData = 8'h00, TxEn = 0, Busy = 0.

Latency, with WrEn = 1 at edge N into an empty FIFO while IDLE:
- Count = 1 and Empty = 0 after edge N.
- The pop occurs at edge N+1: TxEn = 1 and TxData = byte after edge N+1, and Count returns to 0.

Per-byte cycle:
- TxEn falls on the edge following the first sampled TxDone = 1.
- At least one GAP cycle separates consecutive bytes, so TxEn is low for at least 1 cycle between bytes.
- With TxDone already low on GAP entry, the earliest next TxEn rise is 2 edges after TxEn falls: GAP -> IDLE, then the IDLE pop.

Flags:
- Full, Empty, Count and Overflow are all registered.
- Overflow rises on the edge following the rejected write.

## Test plan

- Reset: hold Rst_n = 1 for 3 cycles with WrEn = 1 -> Count = 0, Empty = 1, TxEn = 0, Overflow = 0; nothing is stored.
- Single byte: write 8'hA5 to the empty FIFO at cycle N -> TxEn = 1 and TxData = 8'hA5 from N+2. Pulse TxDone for 1 cycle -> TxEn = 0 on the next edge, Busy falls 2 edges later.
- Ordering and wrap: write 8'h00..8'h1F in bursts with DEPTH = 16, acknowledging every TxEn after 20 cycles -> bytes are transmitted in order 00..1F with no loss and both pointers wrap twice.
- Overflow: with TxDone tied low, write 18 bytes back to back -> 1 byte is in SEND, Count stops at 16 with Full = 1, the remaining write is dropped and Overflow = 1 is sticky.
- Long TxDone: hold TxDone high for 10 cycles with 2 bytes queued -> exactly one byte completes, and the second TxEn rises only after TxDone falls.
- Mid-byte reset: assert Rst_n for 1 cycle while in SEND with 5 bytes queued -> next cycle TxEn = 0, Count = 0, Empty = 1 and no further TxEn.
